// File: rtl/unified_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_responder
// Purpose  : Shared I/D memory responder with programmable wait states.
//            It accepts one request at a time and returns one response beat.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        busy
);

   localparam int         DEPTH       = 1 << ADDR_WIDTH;
   localparam logic [3:0] c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [1:0] c_size_byte = 2'b00;
   localparam logic [1:0] c_size_half = 2'b01;
   localparam logic [1:0] c_size_word = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        w_enter_resp;
   logic        w_accept;
   logic [3:0]  r_count;

   logic        r_write;
   logic        r_unsigned;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        w_cur_write;
   logic        w_cur_unsigned;
   logic [1:0]  w_cur_size;
   logic [31:0] w_cur_addr;
   logic [31:0] w_cur_wdata;

   logic                  w_fault;
   logic [ADDR_WIDTH-1:0] w_word_idx;
   logic [31:0]           w_rd_word;
   logic [7:0]            w_rd_byte;
   logic [15:0]           w_rd_half;
   logic [31:0]           w_load;
   logic [3:0]            w_be;
   logic [31:0]           w_wdata_lanes;
   logic                  w_do_store;

   logic [31:0] r_mem [DEPTH];

   assign w_accept   = (r_state == IDLE) && req_valid;
   assign req_ready  = (r_state == IDLE);
   assign busy       = (r_state != IDLE);
   assign resp_valid = (r_state == RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_enter_resp = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  w_state_next = RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (r_count == 4'd0) begin
               w_state_next = RESP;
               w_enter_resp = 1'b1;
            end
         end
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= 4'd0;
      end else if (w_accept) begin
         r_count <= c_wait_load;
      end else if ((r_state == WAIT) && (r_count != 4'd0)) begin
         r_count <= r_count - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_write    <= 1'b0;
         r_unsigned <= 1'b0;
         r_size     <= 2'b00;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
      end else if (w_accept) begin
         r_write    <= req_write;
         r_unsigned <= req_unsigned;
         r_size     <= req_size;
         r_addr     <= req_addr;
         r_wdata    <= req_wdata;
      end
   end

   // With zero wait states the response is formed on the acceptance edge,
   // so the live request bus stands in for the not-yet-latched copy.
   assign w_cur_write    = (r_state == IDLE) ? req_write    : r_write;
   assign w_cur_unsigned = (r_state == IDLE) ? req_unsigned : r_unsigned;
   assign w_cur_size     = (r_state == IDLE) ? req_size     : r_size;
   assign w_cur_addr     = (r_state == IDLE) ? req_addr     : r_addr;
   assign w_cur_wdata    = (r_state == IDLE) ? req_wdata    : r_wdata;

   assign w_fault = (w_cur_size == 2'b11)
                 || ((w_cur_size == c_size_half) && w_cur_addr[0])
                 || ((w_cur_size == c_size_word) && (w_cur_addr[1:0] != 2'b00))
                 || ((w_cur_addr >> (ADDR_WIDTH + 2)) != 32'd0);

   assign w_word_idx = w_cur_addr[ADDR_WIDTH+1:2];
   assign w_rd_word  = r_mem[w_word_idx];
   assign w_rd_byte  = w_rd_word[{w_cur_addr[1:0], 3'b000} +: 8];
   assign w_rd_half  = w_cur_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

   always_comb begin
      w_load = w_rd_word;
      case (w_cur_size)
         c_size_byte: w_load = {{24{~w_cur_unsigned & w_rd_byte[7]}}, w_rd_byte};
         c_size_half: w_load = {{16{~w_cur_unsigned & w_rd_half[15]}}, w_rd_half};
         default:     w_load = w_rd_word;
      endcase
   end

   always_comb begin
      w_be          = 4'b1111;
      w_wdata_lanes = w_cur_wdata;
      case (w_cur_size)
         c_size_byte: begin
            w_be          = 4'b0001 << w_cur_addr[1:0];
            w_wdata_lanes = {4{w_cur_wdata[7:0]}};
         end
         c_size_half: begin
            w_be          = w_cur_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_lanes = {2{w_cur_wdata[15:0]}};
         end
         default: begin
            w_be          = 4'b1111;
            w_wdata_lanes = w_cur_wdata;
         end
      endcase
   end

   // Reset gating keeps a zero-wait request seen during reset from committing.
   assign w_do_store = w_enter_resp && w_cur_write && !w_fault && !reset;

   always_ff @(posedge clk) begin
      if (w_do_store) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[w_word_idx][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_rdata <= 32'd0;
         resp_fault <= 1'b0;
      end else if (w_enter_resp) begin
         resp_fault <= w_fault;
         resp_rdata <= (w_fault || w_cur_write) ? 32'd0 : w_load;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_responder.sv
`default_nettype none
// Bench for unified_mem_responder: four instances with different wait-state
// counts, a byte-level reference memory model and directed transactions.
module tb_unified_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid, req_write, req_unsigned, req_ready;
   logic [3:0]  resp_valid, resp_fault, busy;
   logic [1:0]  req_size   [4];
   logic [31:0] req_addr   [4];
   logic [31:0] req_wdata  [4];
   logic [31:0] resp_rdata [4];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   function automatic int wc(input int k);
      case (k)
         0:       return 1;
         1:       return 0;
         2:       return 15;
         default: return 3;
      endcase
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      unified_mem_responder #(
         .ADDR_WIDTH (10),
         .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : (g == 2 ? 15 : 3)))
      ) u_dut (
         .clk         (clk),
         .reset       (reset),
         .req_valid   (req_valid[g]),
         .req_ready   (req_ready[g]),
         .req_write   (req_write[g]),
         .req_size    (req_size[g]),
         .req_unsigned(req_unsigned[g]),
         .req_addr    (req_addr[g]),
         .req_wdata   (req_wdata[g]),
         .resp_valid  (resp_valid[g]),
         .resp_rdata  (resp_rdata[g]),
         .resp_fault  (resp_fault[g]),
         .busy        (busy[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic fail_timeout(input string name);
      n_total++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // ---------------- reference model (byte-addressed, timestamp based) -----
   int          cyc;
   bit          m_busy  [4];
   int          m_due   [4];
   logic        m_w     [4];
   logic        m_u     [4];
   logic [1:0]  m_sz    [4];
   logic [31:0] m_a     [4];
   logic [31:0] m_d     [4];
   logic [31:0] m_rdata [4];
   logic        m_fault [4];
   logic [7:0]  mb      [4][4096];

   task automatic commit(input int k);
      logic [31:0] a, v;
      int          nb;
      logic        flt;
      a   = m_a[k];
      nb  = 1 << m_sz[k];
      flt = (m_sz[k] == 2'd3) || ((a % nb) != 0) || (a >= 32'd4096);
      v   = 32'd0;
      if (!flt) begin
         for (int i = 0; i < nb; i++) begin
            if (m_w[k]) mb[k][int'(a) + i] = m_d[k][8*i +: 8];
            else        v[8*i +: 8] = mb[k][int'(a) + i];
         end
         if (!m_w[k] && !m_u[k]) begin
            if (nb == 1 && v[7])  v[31:8]  = '1;
            if (nb == 2 && v[15]) v[31:16] = '1;
         end
      end
      m_fault[k] = flt;
      m_rdata[k] = (flt || m_w[k]) ? 32'd0 : v;
   endtask

   initial begin
      cyc = 0;
      for (int k = 0; k < 4; k++) begin
         m_busy[k] = 0; m_due[k] = 0; m_rdata[k] = 32'd0; m_fault[k] = 1'b0;
      end
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            for (int k = 0; k < 4; k++) begin
               m_busy[k] = 0; m_rdata[k] = 32'd0; m_fault[k] = 1'b0;
            end
         end else begin
            cyc++;
            for (int k = 0; k < 4; k++) begin
               if (m_busy[k] && (cyc - 1 == m_due[k])) begin
                  m_busy[k] = 0;
               end else if (!m_busy[k] && req_valid[k]) begin
                  m_busy[k] = 1;
                  m_due[k]  = cyc + wc(k);
                  m_w[k] = req_write[k]; m_u[k] = req_unsigned[k]; m_sz[k] = req_size[k];
                  m_a[k] = req_addr[k];  m_d[k] = req_wdata[k];
               end
               if (m_busy[k] && (cyc == m_due[k])) commit(k);
            end
         end
      end
   end

   // Every-cycle comparison of all outputs of all instances.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("ready[%0d]", k), 32'(req_ready[k]),  32'(!m_busy[k]));
            chk($sformatf("busy[%0d]", k),  32'(busy[k]),       32'(m_busy[k]));
            chk($sformatf("valid[%0d]", k), 32'(resp_valid[k]), 32'(m_busy[k] && (cyc == m_due[k])));
            chk($sformatf("rdata[%0d]", k), resp_rdata[k],      m_rdata[k]);
            chk($sformatf("fault[%0d]", k), 32'(resp_fault[k]), 32'(m_fault[k]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_ready(input int k);
      int n = 0;
      while (!req_ready[k] && n < 40) begin @(negedge clk); n++; end
      if (!req_ready[k]) fail_timeout("ready");
   endtask

   task automatic xact(input int k, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic f, output int lat);
      @(negedge clk);
      req_valid[k] = 1'b1; req_write[k] = w; req_size[k] = sz; req_unsigned[k] = u;
      req_addr[k] = a; req_wdata[k] = d;
      wait_ready(k);
      @(negedge clk);
      // Scramble the bus once accepted; only latched values may matter.
      req_valid[k] = 1'b0; req_write[k] = ~w; req_size[k] = 2'($urandom);
      req_addr[k] = $urandom; req_wdata[k] = $urandom;
      lat = 1;
      while (!resp_valid[k] && lat < 40) begin @(negedge clk); lat++; end
      if (!resp_valid[k]) fail_timeout("resp");
      rd = resp_rdata[k];
      f  = resp_fault[k];
   endtask

   task automatic op(input int k, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_f, input string name);
      logic [31:0] rd;
      logic        f;
      int          lat;
      xact(k, w, sz, u, a, d, rd, f, lat);
      chk({name, "_rdata"}, rd, exp_rd);
      chk({name, "_fault"}, 32'(f), 32'(exp_f));
      chk({name, "_lat"}, 32'(lat), 32'(1 + wc(k)));
   endtask

   task automatic hold(input int k, input int nresp);
      int cnt = 0;
      int n   = 0;
      @(negedge clk);
      wait_ready(k);
      req_valid[k] = 1'b1; req_write[k] = 1'b0; req_size[k] = 2'd2;
      req_unsigned[k] = 1'b0; req_addr[k] = 32'h40;
      repeat (nresp * (wc(k) + 2)) begin
         @(negedge clk);
         if (resp_valid[k]) cnt++;
      end
      req_valid[k] = 1'b0;
      chk($sformatf("hold_count[%0d]", k), 32'(cnt), 32'(nresp));
      while (busy[k] && n < 40) begin @(negedge clk); n++; end
   endtask

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req_valid[k] = 1'b0; req_write[k] = 1'b0; req_unsigned[k] = 1'b0;
         req_size[k] = 2'd0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
      end
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready[0]),  32'd1);
      chk("rst_valid", 32'(resp_valid[0]), 32'd0);
      chk("rst_busy",  32'(busy[0]),       32'd0);
      chk("rst_rdata", resp_rdata[0],      32'd0);
      chk("rst_fault", 32'(resp_fault[0]), 32'd0);
      #2 reset = 1'b0;

      // Word, byte and half accesses with one wait state
      op(0, 1, 2'd2, 0, 32'h40,   32'hDEADBEEF, 32'h00000000, 0, "sw40");
      op(0, 0, 2'd2, 0, 32'h40,   32'h0,        32'hDEADBEEF, 0, "lw40");
      op(0, 0, 2'd0, 0, 32'h43,   32'h0,        32'hFFFFFFDE, 0, "lb43");
      op(0, 0, 2'd0, 1, 32'h43,   32'h0,        32'h000000DE, 0, "lbu43");
      op(0, 0, 2'd1, 0, 32'h42,   32'h0,        32'hFFFFDEAD, 0, "lh42");
      op(0, 0, 2'd1, 1, 32'h40,   32'h0,        32'h0000BEEF, 0, "lhu40");
      op(0, 1, 2'd0, 0, 32'h41,   32'hFFFFFF55, 32'h00000000, 0, "sb41");
      op(0, 0, 2'd2, 0, 32'h40,   32'h0,        32'hDEAD55EF, 0, "lw40_sb");
      op(0, 0, 2'd1, 0, 32'h41,   32'h0,        32'h00000000, 1, "lh41");
      op(0, 1, 2'd2, 0, 32'h42,   32'h11112222, 32'h00000000, 1, "sw42");
      op(0, 0, 2'd2, 0, 32'h40,   32'h0,        32'hDEAD55EF, 0, "lw40_sw42");
      op(0, 0, 2'd2, 0, 32'h1000, 32'h0,        32'h00000000, 1, "lw1000");
      op(0, 0, 2'd3, 0, 32'h40,   32'h0,        32'h00000000, 1, "size11");

      // Zero and maximum wait states, with back-to-back held requests
      op(1, 1, 2'd2, 0, 32'h40, 32'h01234567, 32'h00000000, 0, "w0_sw");
      op(1, 0, 2'd2, 0, 32'h40, 32'h0,        32'h01234567, 0, "w0_lw");
      hold(1, 4);
      op(2, 1, 2'd2, 0, 32'h40, 32'h89ABCDEF, 32'h00000000, 0, "w15_sw");
      op(2, 0, 2'd0, 0, 32'h42, 32'h0,        32'hFFFFFFAB, 0, "w15_lb");
      hold(2, 2);
      hold(0, 3);

      // Reset during the response cycle: store already committed
      @(negedge clk);
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'd2;
      req_addr[0] = 32'h44; req_wdata[0] = 32'hA5A5A5A5;
      wait_ready(0);
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("rresp_valid", 32'(resp_valid[0]), 32'd1);
      #2 reset = 1'b1;
      #1 chk("rresp_drop", 32'(resp_valid[0]), 32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      op(0, 0, 2'd2, 0, 32'h44, 32'h0, 32'hA5A5A5A5, 0, "rresp_lw");

      // Reset during the second wait cycle: store discarded
      op(3, 1, 2'd2, 0, 32'h80, 32'hCAFEF00D, 32'h00000000, 0, "w3_sw");
      op(3, 0, 2'd1, 0, 32'h81, 32'h0,        32'h00000000, 1, "w3_flt");
      @(negedge clk);
      req_valid[3] = 1'b1; req_write[3] = 1'b1; req_size[3] = 2'd2;
      req_addr[3] = 32'h80; req_wdata[3] = 32'h12345678;
      wait_ready(3);
      @(negedge clk);
      req_valid[3] = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rwait_busy",  32'(busy[3]),       32'd0);
      chk("rwait_ready", 32'(req_ready[3]),  32'd1);
      chk("rwait_valid", 32'(resp_valid[3]), 32'd0);
      chk("rwait_fault", 32'(resp_fault[3]), 32'd0);
      chk("rwait_rdata", resp_rdata[3],      32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("rwait_novalid", 32'(resp_valid[3]), 32'd0);
      end
      op(3, 0, 2'd2, 0, 32'h80, 32'h0, 32'hCAFEF00D, 0, "rwait_lw");

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/unified_mem_responder.md
# unified_mem_responder

Memory-side responder for the multicycle RV32I core's single shared instruction/data port. It accepts one read or write request at a time over a valid/ready handshake and holds it for a programmable number of wait states. It then returns one response beat carrying load data (byte-lane extracted and sign/zero extended) or a fault flag. It replaces the ideal zero-latency memory and lets the core's FETCH/MEM_RD/MEM_WR states be exercised against realistic latency.

## Interface
Parameters:
- ADDR_WIDTH, 10: word-address bits; depth = 2^ADDR_WIDTH 32-bit words, byte range 0 .. 2^(ADDR_WIDTH+2)-1.
- WAIT_CYCLES, 1: extra cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load/fetch.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0] encoding).
- req_unsigned  in  1  zero-extend load data (funct3[2]).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned, out-of-range or illegal size; qualified by resp_valid.
- busy  out  1  high in WAIT and RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** req_ready=1. When req_valid=1, latch write, size, unsigned, addr and wdata. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- **WAIT:** a 4-bit down-counter is loaded with WAIT_CYCLES-1 on acceptance. Stay in WAIT while the counter is nonzero and decrement it. Go to RESP when it reaches 0.
- **RESP:** resp_valid=1 for exactly one cycle, then return to IDLE unconditionally. No acceptance occurs in RESP.
- **Fault:** set when any of the following holds:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]≠00;
  - addr[31:ADDR_WIDTH+2]≠0.
  A faulting store writes nothing. A faulting request returns resp_rdata=0.
- **Store:** committed on the clock edge that enters RESP.
  - Byte: lane addr[1:0] receives wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0].
  - Word: all four lanes written.
  - Other lanes are preserved.
- **Load:** word read at addr[ADDR_WIDTH+1:2]. Select lane(s) by addr[1:0], shift to bit 0, then sign-extend, or zero-extend when req_unsigned=1. Word loads are unextended. Data is registered into resp_rdata on the edge entering RESP.
- resp_rdata and resp_fault hold their values until the next response. resp_rdata is forced to 0 on a store response.
- req_valid while req_ready=0 is ignored: nothing is latched and nothing is queued.
- Memory array contents are not reset and are X until written.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, busy=0, counter=0.
- Acceptance in cycle T gives resp_valid in cycle T+1+WAIT_CYCLES. The next acceptance is possible at cycle T+2+WAIT_CYCLES.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- A read after a write to the same word returns the new data. The write commits before the later request is accepted.
- **Reset asserted in WAIT:** request discarded, no store committed, no resp_valid.
- **Reset asserted in RESP:** the store has already committed, and resp_valid drops immediately.
- req_* inputs may change freely after the acceptance cycle; only latched values are used.

## Test plan
- **Word store then load, WAIT_CYCLES=1:** store 0xDEADBEEF @0x40, then load word @0x40.
  - Each resp_valid occurs 2 cycles after acceptance.
  - Load rdata=0xDEADBEEF, fault=0.
- **Byte/half extension:** with word @0x40 = 0xDEADBEEF:
  - lb @0x43 → 0xFFFFFFDE
  - lbu @0x43 → 0x000000DE
  - lh @0x42 → 0xFFFFDEAD
  - lhu @0x40 → 0x0000BEEF
- **Partial store:** sb 0x55 @0x41 into 0xDEADBEEF, then lw @0x40 → 0xDEAD55EF.
- **Faults:**
  - lh @0x41 → fault=1, rdata=0.
  - sw @0x42 → fault=1; a later lw @0x40 shows the word unchanged.
  - Out-of-range address 0x1000 with ADDR_WIDTH=10 → fault=1.
  - req_size=11 → fault=1.
- **Handshake:** hold req_valid high continuously. req_ready is 0 during WAIT/RESP, and exactly one response occurs per WAIT_CYCLES+2 cycles. Repeat with WAIT_CYCLES=0 (response at T+1) and WAIT_CYCLES=15 (response at T+16).
- **Reset mid-operation:** accept sw 0x12345678 @0x80 with WAIT_CYCLES=3 and assert reset in the second WAIT cycle.
  - Outputs return to reset values and no resp_valid occurs.
  - A later lw @0x80 returns the old contents.
